// File: rtl/score_display_pkg.sv
// Shared types, constants and small helpers for the score display controller.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [6:0] SCORE_MAX   = 7'd99;
    localparam logic [2:0] SHIFT_STEPS = 3'd7;

    // Double-dabble correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    function automatic logic [6:0] sat_score(input logic [6:0] s);
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

endpackage

// File: rtl/score_display_ctrl_scan_tick_gen.sv
// Free-running prescaler: one-cycle scan_en pulse every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic scan_en
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_scan_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_scan_en <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt     <= '0;
            r_scan_en <= 1'b1;
        end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_scan_en <= 1'b0;
        end
    end

    assign scan_en = r_scan_en;

endmodule

// File: rtl/score_display_ctrl.sv
// Score-to-BCD display controller with scan pulse generation.
// Optional blink-after-update masking is compiled in with macro SCORE_BLINK_EN.
module score_display_ctrl
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV   = 25000,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       score_valid,
    input  logic [6:0] score_in,
    output logic       score_ready,
    input  logic       clear,
    output logic       scan_en,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       busy
);

    if (BLINK_HALF < 1) begin : g_blink_half_chk
        $error("BLINK_HALF must be positive");
    end

    state_t     r_state;
    logic [6:0] r_bin;
    logic [7:0] r_bcd;
    logic [2:0] r_cnt;
    logic [3:0] r_d1;
    logic [3:0] r_d0;
    logic [7:0] w_bcd_adj;
    logic [2:0] w_cnt_nxt;
    logic       w_mask;

    assign w_bcd_adj = {dabble_adj(r_bcd[7:4]), dabble_adj(r_bcd[3:0])};
    assign w_cnt_nxt = r_cnt + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_d1    <= DIGIT_BLANK;
            r_d0    <= 4'd0;
        end else if (clear) begin
            r_state <= IDLE;
            r_d1    <= DIGIT_BLANK;
            r_d0    <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (score_valid) begin
                        r_bin   <= sat_score(score_in);
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= w_cnt_nxt;
                    if (w_cnt_nxt == SHIFT_STEPS) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_d0    <= r_bcd[3:0];
                    r_d1    <= (r_bcd[7:4] == 4'd0) ? DIGIT_BLANK : r_bcd[7:4];
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic          r_blink_act;
    logic [1:0]    r_blink_ph;
    logic [BW-1:0] r_blink_cnt;

    // Phases 0 and 2 are the "off" phases; the sequence ends after phase 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_act <= 1'b0;
            r_blink_ph  <= 2'd0;
            r_blink_cnt <= '0;
        end else if (clear) begin
            r_blink_act <= 1'b0;
            r_blink_ph  <= 2'd0;
            r_blink_cnt <= '0;
        end else if (r_state == COMMIT) begin
            r_blink_act <= 1'b1;
            r_blink_ph  <= 2'd0;
            r_blink_cnt <= '0;
        end else if (r_blink_act) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= r_blink_ph + 2'd1;
                if (r_blink_ph == 2'd3) begin
                    r_blink_act <= 1'b0;
                end
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_mask = r_blink_act & ~r_blink_ph[0];
`else
    assign w_mask = 1'b0;
`endif

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .scan_en(scan_en)
    );

    assign score_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign d0          = w_mask ? DIGIT_BLANK : r_d0;
    assign d1          = w_mask ? DIGIT_BLANK : r_d1;
    assign d2          = DIGIT_BLANK;
    assign d3          = DIGIT_BLANK;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: random scores, clears and resets
// against a decimal reference model; a free-running monitor checks each commit.
`timescale 1ns/1ps
module tb_score_display_ctrl;

    localparam int SCAN_DIV   = 8;
    localparam int BLINK_HALF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       score_valid;
    logic [6:0] score_in;
    logic       clear;
    logic       score_ready;
    logic       scan_en;
    logic [3:0] d3, d2, d1, d0;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    score_display_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .score_valid(score_valid),
        .score_in   (score_in),
        .score_ready(score_ready),
        .clear      (clear),
        .scan_en    (scan_en),
        .d3         (d3),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: saturate, split into tens/ones, blank a zero tens digit.
    function automatic logic [7:0] model_digits(input int s);
        int v;
        int tens;
        int ones;
        logic [3:0] t4;
        v    = (s > 99) ? 99 : s;
        tens = v / 10;
        ones = v % 10;
        t4   = (tens == 0) ? 4'hF : 4'(tens);
        return {t4, 4'(ones)};
    endfunction

    // Monitor: scan pulse timing, ready/busy coherence, commit compare, digit stability.
    initial begin
        int unsigned k;
        logic        prev_busy;
        logic [7:0]  prev_dig;
        logic [7:0]  exp;
        int          busy_len;
        k = 0;
        prev_busy = 1'b0;
        prev_dig = 8'hF0;
        busy_len = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                k = 0;
                prev_busy = 1'b0;
                prev_dig = 8'hF0;
                busy_len = 0;
                check("scan_en_in_reset", 32'(scan_en), 32'd0);
            end else begin
                k++;
                check("scan_en", 32'(scan_en), 32'((k % SCAN_DIV) == 0));
                check("ready_vs_busy", 32'(score_ready), 32'(!busy));
                check("d3d2_blank", {24'd0, d3, d2}, 32'h0000_00FF);
                if (prev_busy && !busy) begin
                    if (!clear) check("busy_len", busy_len, 32'd8);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_commit: got %0h expected no commit", {d1, d0});
                    end else begin
                        exp = exp_q.pop_front();
`ifdef SCORE_BLINK_EN
                        if (!clear) exp = 8'hFF;
`endif
                        check("commit_digits", {24'd0, d1, d0}, {24'd0, exp});
                    end
                end else if (!clear) begin
`ifndef SCORE_BLINK_EN
                    check("digits_stable", {24'd0, d1, d0}, {24'd0, prev_dig});
`endif
                end
                busy_len = busy ? busy_len + 1 : 0;
                prev_busy = busy;
                prev_dig = {d1, d0};
            end
        end
    end

    // abort_at > 0 aborts at edge T+abort_at with clear, or with rst when by_rst is set.
    task automatic send(input int s, input int abort_at, input bit by_rst, output int waits);
        score_valid = 1'b1;
        score_in = 7'(s);
        waits = 0;
        while (!score_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!score_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 40 cycles");
            score_valid = 1'b0;
            return;
        end
        @(negedge clk);
        score_valid = 1'b0;
        if (abort_at == 0) begin
            exp_q.push_back(model_digits(s));
        end else begin
            if (!by_rst) exp_q.push_back(8'hF0);
            repeat (abort_at - 1) @(negedge clk);
            if (by_rst) rst = 1'b1;
            else clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        score_valid = 1'b0;
        score_in = '0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d1d0", {24'd0, d1, d0}, 32'h0000_00F0);
        check("rst_ready", 32'(score_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3 * SCAN_DIV) @(negedge clk);

        send(47, 0, 1'b0, w);
        wait_drain();
        send(5, 0, 1'b0, w);
        send(0, 0, 1'b0, w);
        send(120, 0, 1'b0, w);
        wait_drain();

        send(62, 0, 1'b0, w);
        send(33, 0, 1'b0, w);
        check("hold_accept_gap", w, 32'd8);
        wait_drain();

        send(81, 4, 1'b0, w);
        wait_drain();
        check("clear_abort_ready", 32'(score_ready), 32'd1);

        send(81, 4, 1'b1, w);
        check("rst_abort_d1d0", {24'd0, d1, d0}, 32'h0000_00F0);
        check("rst_abort_busy", 32'(busy), 32'd0);
        repeat (2 * SCAN_DIV) @(negedge clk);

        send(99, 0, 1'b0, w);
        wait_drain();
        score_valid = 1'b1;
        score_in = 7'd55;
        clear = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        clear = 1'b0;
        check("clear_blocks_accept", 32'(busy), 32'd0);
        check("idle_clear_d1d0", {24'd0, d1, d0}, 32'h0000_00F0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            int s;
            int ab;
            s = int'($urandom_range(0, 127));
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
            send(s, ab, 1'b0, w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();

`ifdef SCORE_BLINK_EN
        send(12, 0, 1'b0, w);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check("blink_phase", {24'd0, d1, d0},
                  ((i < 4) || (i >= 8 && i < 12)) ? 32'h0000_00FF : 32'h0000_0012);
            @(negedge clk);
        end
        check("blink_steady", {24'd0, d1, d0}, 32'h0000_0012);
        wait_drain();
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish before 500 us");
        $fatal(1, "watchdog expired");
    end

endmodule
